// File: rtl/axis_split_multi_channel.sv
// AXI-stream splitter: cuts each input packet into up to NUM_CH consecutive segments, segment k on channel k.
// Optional macro AXIS_SPLIT_SHORT_FLAG_EN adds short_pkt/short_ch reporting of packets that end before the last channel.
`timescale 1ns/1ps
module axis_split_multi_channel #(
  parameter int DSIZE  = 8,
  parameter int NUM_CH = 4,
  parameter int LSIZE  = 16
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [(NUM_CH-1)*LSIZE-1:0]   split_len,
  input  logic [DSIZE-1:0]              s_tdata,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic [NUM_CH*DSIZE-1:0]       m_tdata,
  output logic [NUM_CH-1:0]             m_tvalid,
  output logic [NUM_CH-1:0]             m_tlast,
  input  logic [NUM_CH-1:0]             m_tready
`ifdef AXIS_SPLIT_SHORT_FLAG_EN
  ,
  output logic                          short_pkt,
  output logic [$clog2(NUM_CH)-1:0]     short_ch
`endif
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int LW   = (NUM_CH-1)*LSIZE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [LSIZE-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]             len_q, len_d;

  logic [LW-1:0]             lens_p0;
  logic [CH_W-1:0]           tgt_ch_p0;
  logic [LSIZE-1:0]          cnt_p0;
  logic [LSIZE-1:0]          seg_len_p0;
  logic [LSIZE:0]            cnt_inc_p0;
  logic                      seg_end_p0;
  logic                      xfer_p0;
  logic                      tgt_vld_p0;
  logic                      tgt_rdy_p0;

  logic [NUM_CH-1:0]         vld_p1;
  logic [NUM_CH-1:0]         last_p1;
  logic [NUM_CH*DSIZE-1:0]   data_p1;

  // Length of segment ch; the last channel has no length field and reports 0.
  function automatic logic [LSIZE-1:0] seg_len(input logic [LW-1:0] lens,
                                                input logic [CH_W-1:0] ch);
    logic [LSIZE-1:0] res;
    res = '0;
    for (int k = 0; k < NUM_CH-1; k++) begin
      if (int'(ch) == k) res = lens[k*LSIZE +: LSIZE];
    end
    return res;
  endfunction

  // Lowest channel at or above 'from' with a non-zero length, else the last channel.
  function automatic logic [CH_W-1:0] first_nz(input logic [LW-1:0] lens,
                                                input int from);
    logic [CH_W-1:0] res;
    res = CH_W'(NUM_CH-1);
    for (int k = NUM_CH-2; k >= 0; k--) begin
      if (k >= from && lens[k*LSIZE +: LSIZE] != '0) res = CH_W'(k);
    end
    return res;
  endfunction

  // Stage p0: target channel and segment-end decode for the beat on the input.
  always_comb begin
    lens_p0    = (state_q == IDLE) ? split_len : len_q;
    tgt_ch_p0  = (state_q == IDLE) ? first_nz(split_len, 0) : ch_q;
    cnt_p0     = (state_q == IDLE) ? '0 : cnt_q;
    seg_len_p0 = seg_len(lens_p0, tgt_ch_p0);
    cnt_inc_p0 = {1'b0, cnt_p0} + (LSIZE+1)'(1);
    seg_end_p0 = (int'(tgt_ch_p0) < NUM_CH-1) && (cnt_inc_p0 == {1'b0, seg_len_p0});
    tgt_vld_p0 = vld_p1[tgt_ch_p0];
    tgt_rdy_p0 = m_tready[tgt_ch_p0];
    s_tready   = !tgt_vld_p0 || tgt_rdy_p0;
    xfer_p0    = s_tvalid && s_tready;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (xfer_p0) begin
      if (state_q == IDLE) len_d = split_len;
      if (s_tlast) begin
        state_d = IDLE;
        ch_d    = '0;
        cnt_d   = '0;
      end else if (seg_end_p0) begin
        state_d = RUN;
        ch_d    = first_nz(lens_p0, int'(tgt_ch_p0) + 1);
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        ch_d    = tgt_ch_p0;
        cnt_d   = cnt_inc_p0[LSIZE-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Stage p1: one output register per channel.
  always_ff @(posedge clock) begin
    if (rst) begin
      vld_p1  <= '0;
      last_p1 <= '0;
      data_p1 <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (xfer_p0 && int'(tgt_ch_p0) == k) begin
          vld_p1[k]                  <= 1'b1;
          last_p1[k]                 <= s_tlast || seg_end_p0;
          data_p1[k*DSIZE +: DSIZE]  <= s_tdata;
        end else if (m_tready[k]) begin
          vld_p1[k]  <= 1'b0;
          last_p1[k] <= 1'b0;
        end
      end
    end
  end

  assign m_tvalid = vld_p1;
  assign m_tlast  = last_p1;
  assign m_tdata  = data_p1;

`ifdef AXIS_SPLIT_SHORT_FLAG_EN
  logic short_hit_p0;
  assign short_hit_p0 = xfer_p0 && s_tlast && (int'(tgt_ch_p0) < NUM_CH-1);

  always_ff @(posedge clock) begin
    if (rst) begin
      short_pkt <= 1'b0;
      short_ch  <= '0;
    end else begin
      short_pkt <= short_hit_p0;
      if (short_hit_p0) short_ch <= tgt_ch_p0;
    end
  end
`endif

endmodule

// File: tb/tb_axis_split_multi_channel.sv
// Bench for axis_split_multi_channel: directed and random packets checked against a segment-allocation model.
`timescale 1ns/1ps
module tb_axis_split_multi_channel;

  localparam int DSIZE  = 8;
  localparam int NUM_CH = 4;
  localparam int LSIZE  = 16;
  localparam int LW     = (NUM_CH-1)*LSIZE;

  typedef struct packed {
    logic [DSIZE-1:0] d;
    logic             l;
  } beat_t;

  logic                        clock = 1'b0;
  logic                        rst = 1'b1;
  logic [LW-1:0]               split_len = '0;
  logic [DSIZE-1:0]            s_tdata = '0;
  logic                        s_tvalid = 1'b0;
  logic                        s_tlast = 1'b0;
  logic                        s_tready;
  logic [NUM_CH*DSIZE-1:0]     m_tdata;
  logic [NUM_CH-1:0]           m_tvalid;
  logic [NUM_CH-1:0]           m_tlast;
  logic [NUM_CH-1:0]           m_tready = '1;
`ifdef AXIS_SPLIT_SHORT_FLAG_EN
  localparam int CW = $clog2(NUM_CH);
  logic                        short_pkt;
  logic [CW-1:0]               short_ch;
`endif

  int    errors = 0;
  int    checks = 0;
  int    stall_cnt = 0;
  int    hold1 = 0;
  bit    stall_arm = 1'b0;
  bit    rand_rdy = 1'b0;
  logic [DSIZE-1:0] pkt_d [64];
  int    tgt [64];
  beat_t exp_q [NUM_CH][$];
  int    exp_short [$];

  axis_split_multi_channel #(.DSIZE(DSIZE), .NUM_CH(NUM_CH), .LSIZE(LSIZE)) dut (
    .clock(clock), .rst(rst), .split_len(split_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
`ifdef AXIS_SPLIT_SHORT_FLAG_EN
    , .short_pkt(short_pkt), .short_ch(short_ch)
`endif
  );

  always #5 clock = ~clock;

  // Consumer ready pattern: all-ready, random, or channel 1 held off once it fills.
  always @(posedge clock) begin
    logic [NUM_CH-1:0] rdy;
    #1;
    if (stall_arm && m_tvalid[1]) begin
      hold1 = 5;
      stall_arm = 1'b0;
    end
    rdy = rand_rdy ? NUM_CH'($urandom) : '1;
    if (hold1 > 0) begin
      rdy[1] = 1'b0;
      hold1--;
    end
    m_tready = rdy;
  end

  // Output monitor: each accepted beat must be the next expected one on its channel.
  always @(negedge clock) begin
    beat_t e;
    if (rst === 1'b0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_tvalid[k] === 1'b1 && m_tready[k] === 1'b1) begin
          checks++;
          assert (exp_q[k].size() > 0) else begin
            errors++;
            $error("FAIL ch%0d_extra_beat got data=%h last=%b required none", k, m_tdata[k*DSIZE +: DSIZE], m_tlast[k]);
          end
          if (exp_q[k].size() > 0) begin
            e = exp_q[k].pop_front();
            checks++;
            assert ({m_tdata[k*DSIZE +: DSIZE], m_tlast[k]} === {e.d, e.l}) else begin
              errors++;
              $error("FAIL ch%0d_beat got data=%h last=%b required data=%h last=%b",
                     k, m_tdata[k*DSIZE +: DSIZE], m_tlast[k], e.d, e.l);
            end
          end
        end
      end
    end
  end

`ifdef AXIS_SPLIT_SHORT_FLAG_EN
  always @(negedge clock) begin
    int e;
    if (rst === 1'b0 && short_pkt === 1'b1) begin
      checks++;
      assert (exp_short.size() > 0) else begin
        errors++;
        $error("FAIL short_pkt_extra got 1 required 0");
      end
      if (exp_short.size() > 0) begin
        e = exp_short.pop_front();
        checks++;
        assert (short_ch === CW'(e)) else begin
          errors++;
          $error("FAIL short_ch got %0d required %0d", short_ch, e);
        end
      end
    end
  end
`endif

  // Model: segment k takes min(len[k], remaining) beats, the last channel takes the rest.
  task automatic model_packet(input int n, input logic [LW-1:0] lens);
    int pos, take, lk;
    beat_t b;
    pos = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k < NUM_CH-1) begin
        lk = int'(lens[k*LSIZE +: LSIZE]);
        take = (lk < n - pos) ? lk : n - pos;
      end else begin
        take = n - pos;
      end
      for (int j = 0; j < take; j++) begin
        b.d = pkt_d[pos+j];
        b.l = (j == take-1);
        exp_q[k].push_back(b);
        tgt[pos+j] = k;
      end
      pos += take;
    end
    if (tgt[n-1] < NUM_CH-1) exp_short.push_back(tgt[n-1]);
  endtask

  task automatic send_packet(input int n, input logic [LW-1:0] lens, input int stop_after, input int base);
    int   waited;
    logic hs, exp_rdy;
    for (int i = 0; i < n; i++) pkt_d[i] = (base >= 0) ? DSIZE'(base + i) : DSIZE'($urandom);
    model_packet(n, lens);
    for (int i = 0; i < n && i < stop_after; i++) begin
      s_tvalid  = 1'b1;
      s_tdata   = pkt_d[i];
      s_tlast   = (i == n-1);
      split_len = (i == 0) ? lens : LW'({$urandom, $urandom});
      waited = 0;
      forever begin
        @(negedge clock);
        exp_rdy = !m_tvalid[tgt[i]] || m_tready[tgt[i]];
        checks++;
        assert (s_tready === exp_rdy) else begin
          errors++;
          $error("FAIL s_tready beat%0d got %b required %b", i, s_tready, exp_rdy);
        end
        hs = s_tready;
        @(posedge clock); #1;
        if (hs === 1'b1) break;
        stall_cnt++;
        waited++;
        if (waited > 300) begin
          checks++;
          errors++;
          $error("FAIL handshake_timeout beat%0d got no s_tready required handshake", i);
          break;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    repeat (20) @(posedge clock);
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      assert (exp_q[k].size() === 0) else begin
        errors++;
        $error("FAIL %s_ch%0d_missing got %0d beats outstanding required 0", tag, k, exp_q[k].size());
      end
    end
`ifdef AXIS_SPLIT_SHORT_FLAG_EN
    checks++;
    assert (exp_short.size() === 0) else begin
      errors++;
      $error("FAIL %s_short_missing got %0d outstanding required 0", tag, exp_short.size());
    end
`endif
  endtask

  initial begin
    logic [LW-1:0] lens;

    // Reset state
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    checks++; assert (m_tvalid === '0) else begin errors++; $error("FAIL rst_tvalid got %b required 0", m_tvalid); end
    checks++; assert (m_tlast === '0) else begin errors++; $error("FAIL rst_tlast got %b required 0", m_tlast); end
    checks++; assert (m_tdata === '0) else begin errors++; $error("FAIL rst_tdata got %h required 0", m_tdata); end
    checks++; assert (s_tready === 1'b1) else begin errors++; $error("FAIL rst_tready got %b required 1", s_tready); end
    @(posedge clock); #1;

    // 1: lengths 2/3/1, data 0..9, full throughput
    stall_cnt = 0;
    send_packet(10, {16'd1, 16'd3, 16'd2}, 99, 0);
    checks++; assert (stall_cnt === 0) else begin errors++; $error("FAIL t1_stalls got %0d required 0", stall_cnt); end
    drain_and_check("t1");

    // 2: zero-length segments skipped
    send_packet(5, {16'd0, 16'd2, 16'd0}, 99, 10);
    drain_and_check("t2");

    // 3: short packet ends on channel 1
    send_packet(6, {16'd4, 16'd4, 16'd4}, 99, -1);
    drain_and_check("t3");

    // 4: back-pressure on channel 1
    stall_cnt = 0;
    stall_arm = 1'b1;
    send_packet(10, {16'd1, 16'd3, 16'd2}, 99, 32);
    checks++; assert (stall_cnt >= 4) else begin errors++; $error("FAIL t4_stalls got %0d required >=4", stall_cnt); end
    drain_and_check("t4");

    // 5: back-to-back packets, mid-packet split_len scrambled by the driver
    stall_cnt = 0;
    send_packet(4, {16'd1, 16'd1, 16'd1}, 99, 64);
    send_packet(5, {16'd2, 16'd0, 16'd0}, 99, 80);
    checks++; assert (stall_cnt === 0) else begin errors++; $error("FAIL t5_bubble got %0d stalls required 0", stall_cnt); end
    drain_and_check("t5");

    // 6: reset in the middle of a packet
    send_packet(10, {16'd3, 16'd3, 16'd3}, 3, 96);
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    exp_short.delete();
    @(negedge clock);
    checks++; assert (m_tvalid === '0) else begin errors++; $error("FAIL t6_flush got %b required 0", m_tvalid); end
    @(posedge clock); #1;
    send_packet(3, {16'd1, 16'd1, 16'd1}, 99, 112);
    drain_and_check("t6");

    // Boundaries: maximum length field, empty remainder, single beat to last channel
    send_packet(5, {16'd0, 16'd0, 16'hFFFF}, 99, -1);
    send_packet(1, {16'd0, 16'd0, 16'd1}, 99, -1);
    send_packet(1, {16'd0, 16'd0, 16'd0}, 99, -1);
    send_packet(3, {16'd0, 16'd1, 16'd2}, 99, -1);
    drain_and_check("bnd");

    // Random packets with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 25; p++) begin
      lens = {LSIZE'($urandom_range(0, 4)), LSIZE'($urandom_range(0, 4)), LSIZE'($urandom_range(0, 4))};
      send_packet($urandom_range(1, 12), lens, 99, -1);
    end
    rand_rdy = 1'b0;
    drain_and_check("rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
